// File: rtl/mem_responder.sv
// Tagged block-memory responder: one command per cycle, fixed-latency load returns.
// Define MEM_RESP_STATS_EN to add the load/store/reject/peak-busy statistics ports.
module mem_responder #(
    parameter int LATENCY   = 10,
    parameter int NUM_TAGS  = 15,
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_transaction_tag,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_data_tag
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_rejects,
    output logic [3:0]  stat_max_busy
`endif
);

    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [63:0] data;
    } resp_t;

    logic [63:0]       mem [MEM_WORDS];
    logic [NUM_TAGS:1] busy_q;
    logic [NUM_TAGS:1] busy_d;
    resp_t             pipe_q [LATENCY];
    resp_t             head;
    resp_t             stage_in;

    logic        is_load;
    logic        is_store;
    logic [28:0] idx;
    logic        in_range;
    logic [3:0]  grant;
    logic        accept;
    logic [63:0] rd_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        unique case (1'b1)
            (proc2mem_command == MEM_LOAD):  is_load  = 1'b1;
            (proc2mem_command == MEM_STORE): is_store = 1'b1;
            default: ;
        endcase
    end

    assign idx      = proc2mem_addr[31:3];
    assign in_range = (32'(idx) < MEM_WORDS);
    assign rd_data  = in_range ? mem[idx[AW-1:0]] : 64'h0;

    // Only busy_q is consulted, so a tag returning this cycle stays ungrantable.
    always_comb begin
        grant = 4'd0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!busy_q[i]) grant = 4'(i);
        end
    end

    assign accept = is_load && !reset && (grant != 4'd0);
    assign mem2proc_transaction_tag = accept ? grant : 4'd0;

    assign head = pipe_q[LATENCY-1];

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (head.valid && head.tag == 4'(i)) busy_d[i] = 1'b0;
            if (accept && grant == 4'(i))        busy_d[i] = 1'b1;
        end
    end

    always_comb begin
        stage_in.valid = accept;
        stage_in.tag   = accept ? grant : 4'd0;
        stage_in.data  = accept ? rd_data : 64'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            busy_q    <= busy_d;
            pipe_q[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Store array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (is_store && in_range && !reset) mem[idx[AW-1:0]] <= proc2mem_data;
    end

    assign mem2proc_data_tag = head.valid ? head.tag  : 4'd0;
    assign mem2proc_data     = head.valid ? head.data : 64'h0;

`ifdef MEM_RESP_STATS_EN
    logic [3:0] busy_cnt;
    logic       reject;

    assign reject = is_load && !reset && (grant == 4'd0);

    always_comb begin
        busy_cnt = 4'd0;
        for (int i = 1; i <= NUM_TAGS; i++) busy_cnt = busy_cnt + {3'b0, busy_d[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads    <= '0;
            stat_stores   <= '0;
            stat_rejects  <= '0;
            stat_max_busy <= '0;
        end else begin
            if (accept && stat_loads != '1)    stat_loads   <= stat_loads + 32'd1;
            if (is_store && stat_stores != '1) stat_stores  <= stat_stores + 32'd1;
            if (reject && stat_rejects != '1)  stat_rejects <= stat_rejects + 32'd1;
            if (busy_cnt > stat_max_busy)      stat_max_busy <= busy_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: tags, latency, recycling, range and reset.
module tb_mem_responder;

    localparam logic [1:0] NO = 2'd0;
    localparam logic [1:0] LD = 2'd1;
    localparam logic [1:0] ST = 2'd2;
    localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd, cmd2;
    logic [31:0] addr, addr2;
    logic [63:0] wdata, wdata2;
    logic [3:0]  ttag, ttag2, rtag, rtag2;
    logic [63:0] rdata, rdata2;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] sl, ss, sr, sl2, ss2, sr2;
    logic [3:0]  sm, sm2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(10)) dut (
        .clk(clk), .reset(reset),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_transaction_tag(ttag), .mem2proc_data(rdata),
        .mem2proc_data_tag(rtag)
`ifdef MEM_RESP_STATS_EN
        , .stat_loads(sl), .stat_stores(ss), .stat_rejects(sr), .stat_max_busy(sm)
`endif
    );

    mem_responder #(.LATENCY(20)) dut20 (
        .clk(clk), .reset(reset),
        .proc2mem_command(cmd2), .proc2mem_addr(addr2), .proc2mem_data(wdata2),
        .mem2proc_transaction_tag(ttag2), .mem2proc_data(rdata2),
        .mem2proc_data_tag(rtag2)
`ifdef MEM_RESP_STATS_EN
        , .stat_loads(sl2), .stat_stores(ss2), .stat_rejects(sr2), .stat_max_busy(sm2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        cmd = c; addr = a; wdata = d;
        #1;
    endtask

    task automatic drive2(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        cmd2 = c; addr2 = a; wdata2 = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(LD, 32'h0, 64'h0);
        drive2(LD, 32'h0, 64'h0);
        tests++;
        if (ttag !== 4'd0) begin
            fails++; $display("FAIL reset_ttag got %0d want 0", ttag);
        end
        tick(); tick();
        tests++;
        if (rtag !== 4'd0 || rdata !== 64'h0) begin
            fails++; $display("FAIL reset_resp got %0d/%h want 0/0", rtag, rdata);
        end
        tests++;
        if (rtag2 !== 4'd0) begin
            fails++; $display("FAIL reset_resp20 got %0d want 0", rtag2);
        end
        drive(NO, 32'h0, 64'h0);
        drive2(NO, 32'h0, 64'h0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        logic [3:0] exp;
        drive(ST, 32'h40, BEEF);
        tests++;
        if (ttag !== 4'd0) begin
            fails++; $display("FAIL store_ttag got %0d want 0", ttag);
        end
        tick();
        drive(LD, 32'h40, 64'h0);
        tests++;
        if (ttag !== 4'd1) begin
            fails++; $display("FAIL load_ttag got %0d want 1", ttag);
        end
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 1; k <= 11; k++) begin
            exp = (k == 10) ? 4'd1 : 4'd0;
            tests++;
            if (rtag !== exp) begin
                fails++; $display("FAIL sl_rtag k=%0d got %0d want %0d", k, rtag, exp);
            end
            if (k == 10) begin
                tests++;
                if (rdata !== BEEF) begin
                    fails++; $display("FAIL sl_data got %h want %h", rdata, BEEF);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp;
        logic [63:0] expd;
        for (int i = 0; i < 3; i++) begin
            drive(ST, 32'(i * 8), 64'hA0 + 64'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(LD, 32'(i * 8), 64'h0);
            tests++;
            if (ttag !== 4'(i + 1)) begin
                fails++; $display("FAIL b2b_ttag i=%0d got %0d want %0d", i, ttag, i + 1);
            end
            tick();
        end
        drive(NO, 32'h0, 64'h0);
        for (int k = 3; k <= 13; k++) begin
            exp  = (k >= 10 && k <= 12) ? 4'(k - 9) : 4'd0;
            expd = (k >= 10 && k <= 12) ? 64'hA0 + 64'(k - 10) : 64'h0;
            tests++;
            if (rtag !== exp || rdata !== expd) begin
                fails++;
                $display("FAIL b2b_resp k=%0d got %0d/%h want %0d/%h", k, rtag, rdata, exp, expd);
            end
            tick();
        end
    endtask

    task automatic test_recycle();
        drive(LD, 32'h0, 64'h0);
        tests++;
        if (ttag !== 4'd1) begin
            fails++; $display("FAIL rec_t1 got %0d want 1", ttag);
        end
        tick();
        drive(LD, 32'h8, 64'h0);
        tests++;
        if (ttag !== 4'd2) begin
            fails++; $display("FAIL rec_t2 got %0d want 2", ttag);
        end
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 2; k < 10; k++) tick();
        drive(LD, 32'h10, 64'h0);
        tests++;
        if (rtag !== 4'd1 || ttag !== 4'd3) begin
            fails++; $display("FAIL rec_skip got rtag %0d ttag %0d want 1/3", rtag, ttag);
        end
        tick();
        drive(LD, 32'h10, 64'h0);
        tests++;
        if (rtag !== 4'd2 || ttag !== 4'd1) begin
            fails++; $display("FAIL rec_reuse got rtag %0d ttag %0d want 2/1", rtag, ttag);
        end
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_out_of_range();
        drive(LD, 32'h8000, 64'h0);
        tests++;
        if (ttag !== 4'd1) begin
            fails++; $display("FAIL oor_ttag got %0d want 1", ttag);
        end
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 1; k < 10; k++) tick();
        tests++;
        if (rtag !== 4'd1 || rdata !== 64'h0) begin
            fails++; $display("FAIL oor_resp got %0d/%h want 1/0", rtag, rdata);
        end
        tick();
        drive(ST, 32'h8000, 64'h1234);
        tick();
        drive(LD, 32'h0, 64'h0);
        tests++;
        if (ttag !== 4'd1) begin
            fails++; $display("FAIL oor_t1 got %0d want 1", ttag);
        end
        tick();
        drive(LD, 32'h8000, 64'h0);
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 2; k < 10; k++) tick();
        tests++;
        if (rtag !== 4'd1 || rdata !== 64'hA0) begin
            fails++; $display("FAIL oor_alias got %0d/%h want 1/a0", rtag, rdata);
        end
        tick();
        tests++;
        if (rtag !== 4'd2 || rdata !== 64'h0) begin
            fails++; $display("FAIL oor_drop got %0d/%h want 2/0", rtag, rdata);
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(LD, 32'h40, 64'h0);
            tick();
        end
        drive(NO, 32'h0, 64'h0);
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (rtag !== 4'd0 || rdata !== 64'h0) begin
            fails++; $display("FAIL rm_clear got %0d/%h want 0/0", rtag, rdata);
        end
        drive(LD, 32'h40, 64'h0);
        tests++;
        if (ttag !== 4'd1) begin
            fails++; $display("FAIL rm_ttag got %0d want 1", ttag);
        end
        tick();
        drive(NO, 32'h0, 64'h0);
        for (int k = 1; k <= 12; k++) begin
            exp = (k == 10) ? 4'd1 : 4'd0;
            tests++;
            if (rtag !== exp) begin
                fails++; $display("FAIL rm_rtag k=%0d got %0d want %0d", k, rtag, exp);
            end
            if (k == 10) begin
                tests++;
                if (rdata !== BEEF) begin
                    fails++; $display("FAIL rm_data got %h want %h", rdata, BEEF);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency20();
        logic [3:0] exp;
        drive2(ST, 32'h0, 64'h55);
        tick();
        for (int i = 0; i < 22; i++) begin
            drive2(LD, 32'h0, 64'h0);
            exp = (i < 15) ? 4'(i + 1) : ((i == 21) ? 4'd1 : 4'd0);
            tests++;
            if (ttag2 !== exp) begin
                fails++; $display("FAIL l20_ttag i=%0d got %0d want %0d", i, ttag2, exp);
            end
            if (i == 20) begin
                tests++;
                if (rtag2 !== 4'd1 || rdata2 !== 64'h55) begin
                    fails++; $display("FAIL l20_resp1 got %0d/%h want 1/55", rtag2, rdata2);
                end
`ifdef MEM_RESP_STATS_EN
                tests++;
                if (sr2 !== 32'd5) begin
                    fails++; $display("FAIL l20_rejects got %0d want 5", sr2);
                end
`endif
            end
            if (i == 21) begin
                tests++;
                if (rtag2 !== 4'd2) begin
                    fails++; $display("FAIL l20_resp2 got %0d want 2", rtag2);
                end
            end
            tick();
        end
        drive2(NO, 32'h0, 64'h0);
`ifdef MEM_RESP_STATS_EN
        tests++;
        if (sl2 !== 32'd16 || ss2 !== 32'd1 || sr2 !== 32'd6 || sm2 !== 4'd15) begin
            fails++;
            $display("FAIL l20_stats got %0d/%0d/%0d/%0d want 16/1/6/15", sl2, ss2, sr2, sm2);
        end
`endif
        for (int k = 0; k < 22; k++) tick();
    endtask

    initial begin
        cmd = NO; addr = '0; wdata = '0;
        cmd2 = NO; addr2 = '0; wdata2 = '0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_recycle();
        test_out_of_range();
        test_reset_mid();
        test_latency20();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
